// File: rtl/and_nway_pipe.sv
// N-input AND reduction: combinational result plus a registered (optionally per-level pipelined) result with valid.
// Define AND_NWAY_ZERO_IDX_EN to add zero_found / zero_idx (lowest zero-bit locator).
module and_nway_pipe #(
  parameter int NB_IN    = 8,
  parameter int PIPELINE = 1,
  parameter int FANIN    = 4
) (
  output logic             out,
  input  logic [NB_IN-1:0] ins,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             out_q,
  output logic             out_valid
`ifdef AND_NWAY_ZERO_IDX_EN
  ,
  output logic             zero_found,
  output logic [((NB_IN > 1) ? $clog2(NB_IN) : 1)-1:0] zero_idx
`endif
);

  function automatic int f_lvl_w(input int k);
    int w;
    w = NB_IN;
    for (int i = 0; i < k; i++) w = (w + FANIN - 1) / FANIN;
    return w;
  endfunction

  function automatic int f_levels();
    int w;
    int l;
    w = NB_IN;
    l = 0;
    for (int i = 0; i < 32; i++) begin
      if (w > 1) begin
        w = (w + FANIN - 1) / FANIN;
        l++;
      end
    end
    return (l < 1) ? 1 : l;
  endfunction

  function automatic int f_off(input int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += f_lvl_w(i);
    return s;
  endfunction

  localparam int L      = f_levels();
  localparam int NODE_W = f_off(L);
  localparam int AND_W  = f_off(L + 1) - NB_IN;
  localparam int FIN    = AND_W - 1;

  // w_node packs tree levels 0..L-1 back to back; w_and packs each level's group results.
  logic [NODE_W-1:0] w_node;
  logic [AND_W-1:0]  w_and;
  logic              w_vld_fin;

  assign out = &ins;
  assign w_node[NB_IN-1:0] = ins;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int WI = f_lvl_w(k);
    localparam int WO = f_lvl_w(k + 1);
    localparam int OI = f_off(k);
    localparam int OA = f_off(k + 1) - NB_IN;
    for (genvar g = 0; g < WO; g++) begin : g_grp
      logic [FANIN-1:0] w_grp;
      for (genvar j = 0; j < FANIN; j++) begin : g_leaf
        if (g * FANIN + j < WI) begin : g_real
          assign w_grp[j] = w_node[OI + g * FANIN + j];
        end else begin : g_pad
          assign w_grp[j] = 1'b1;
        end
      end
      assign w_and[OA + g] = &w_grp;
    end
  end

  if (L > 1) begin : g_mid
    localparam int MID_W = NODE_W - NB_IN;
    if (PIPELINE != 0) begin : g_pipe
      logic [MID_W-1:0] r_node_p;
      logic [L-2:0]     r_vld_p;

      // stage boundary: every intermediate tree level is registered
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_node_p <= '0;
          r_vld_p  <= '0;
        end else begin
          r_node_p   <= w_and[MID_W-1:0];
          r_vld_p[0] <= in_valid;
          for (int i = 1; i < L - 1; i++) r_vld_p[i] <= r_vld_p[i-1];
        end
      end

      assign w_node[NODE_W-1:NB_IN] = r_node_p;
      assign w_vld_fin = r_vld_p[L-2];
    end else begin : g_comb
      assign w_node[NODE_W-1:NB_IN] = w_and[MID_W-1:0];
      assign w_vld_fin = in_valid;
    end
  end else begin : g_single
    assign w_vld_fin = in_valid;
  end

  // stage boundary: final register holds its value between accepted results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= w_vld_fin;
      if (w_vld_fin) out_q <= w_and[FIN];
    end
  end

`ifdef AND_NWAY_ZERO_IDX_EN
  localparam int ZW = (NB_IN > 1) ? $clog2(NB_IN) : 1;

  assign zero_found = ~out;

  always_comb begin
    zero_idx = '0;
    for (int i = NB_IN - 1; i >= 0; i--) begin
      if (!ins[i]) zero_idx = ZW'(i);
    end
  end
`endif

endmodule

// File: tb/tb_and_nway_pipe.sv
// Scoreboard bench for and_nway_pipe: four instances (8b pipelined, 8b single-register, 1b, 13b padded tree).
// Stimulus pushes expected results with their due cycle; a negedge monitor pops and compares.
module tb_and_nway_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ins8;
  logic [0:0]  ins1;
  logic [12:0] ins13;
  logic        iv8;
  logic        iv13;

  logic out_a, oq_a, ov_a;
  logic out_b, oq_b, ov_b;
  logic out_c, oq_c, ov_c;
  logic out_d, oq_d, ov_d;
`ifdef AND_NWAY_ZERO_IDX_EN
  logic       zf_a, zf_b, zf_c, zf_d;
  logic [2:0] zi_a, zi_b;
  logic [0:0] zi_c;
  logic [3:0] zi_d;
`endif

  always #5 clk = ~clk;

  and_nway_pipe #(.NB_IN(8), .PIPELINE(1), .FANIN(4)) u_a (
    .out(out_a), .ins(ins8), .clk(clk), .rst(rst), .in_valid(iv8),
    .out_q(oq_a), .out_valid(ov_a)
`ifdef AND_NWAY_ZERO_IDX_EN
    , .zero_found(zf_a), .zero_idx(zi_a)
`endif
  );

  and_nway_pipe #(.NB_IN(8), .PIPELINE(0), .FANIN(4)) u_b (
    .out(out_b), .ins(ins8), .clk(clk), .rst(rst), .in_valid(iv8),
    .out_q(oq_b), .out_valid(ov_b)
`ifdef AND_NWAY_ZERO_IDX_EN
    , .zero_found(zf_b), .zero_idx(zi_b)
`endif
  );

  and_nway_pipe #(.NB_IN(1), .PIPELINE(1), .FANIN(4)) u_c (
    .out(out_c), .ins(ins1), .clk(clk), .rst(rst), .in_valid(iv8),
    .out_q(oq_c), .out_valid(ov_c)
`ifdef AND_NWAY_ZERO_IDX_EN
    , .zero_found(zf_c), .zero_idx(zi_c)
`endif
  );

  and_nway_pipe #(.NB_IN(13), .PIPELINE(1), .FANIN(4)) u_d (
    .out(out_d), .ins(ins13), .clk(clk), .rst(rst), .in_valid(iv13),
    .out_q(oq_d), .out_valid(ov_d)
`ifdef AND_NWAY_ZERO_IDX_EN
    , .zero_found(zf_d), .zero_idx(zi_d)
`endif
  );

  typedef struct {
    logic v;
    int   due;
  } exp_t;

  exp_t sbq[4][$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Directed back-to-back vectors with hand-computed results.
  logic [7:0]  t8   [8] = '{8'hFF, 8'h7F, 8'hFE, 8'hFF, 8'h00, 8'hF7, 8'hFF, 8'h80};
  logic        tv8  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic        te8  [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        te1  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [12:0] t13  [8] = '{13'h1FFF, 13'h1FFE, 13'h0FFF, 13'h1FFF, 13'h1EFF, 13'h1FFF, 13'h17FF, 13'h1FFF};
  logic        te13 [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic issue(input logic v8, input logic [7:0] x8, input logic e8, input logic e1,
                       input logic v13, input logic [12:0] x13, input logic e13);
    exp_t e;
    @(posedge clk);
    #1;
    ins8  = x8;
    ins1  = x8[0];
    iv8   = v8;
    ins13 = x13;
    iv13  = v13;
    if (v8) begin
      e.v = e8; e.due = cyc + 2; sbq[0].push_back(e);
      e.v = e8; e.due = cyc + 1; sbq[1].push_back(e);
      e.v = e1; e.due = cyc + 1; sbq[2].push_back(e);
    end
    if (v13) begin
      e.v = e13; e.due = cyc + 2; sbq[3].push_back(e);
    end
  endtask

  task automatic idle();
    issue(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0);
  endtask

  task automatic mon(input int id, input string nm, input logic ov, input logic oq);
    exp_t e;
    if (sbq[id].size() > 0 && sbq[id][0].due < cyc) begin
      e = sbq[id].pop_front();
      chk({nm, " result by cycle"}, cyc, e.due);
    end
    if (ov === 1'b1) begin
      if (sbq[id].size() == 0) begin
        chk({nm, " stray out_valid"}, ov, 0);
      end else begin
        e = sbq[id].pop_front();
        chk({nm, " out_q"}, oq, e.v);
        chk({nm, " latency cycle"}, cyc, e.due);
      end
    end else if (ov !== 1'b0) begin
      chk({nm, " out_valid known"}, ov, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon(0, "A", ov_a, oq_a);
      mon(1, "B", ov_b, oq_b);
      mon(2, "C", ov_c, oq_c);
      mon(3, "D", ov_d, oq_d);
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, " A out_q"}, oq_a, 0);
    chk({tag, " A out_valid"}, ov_a, 0);
    chk({tag, " B out_q"}, oq_b, 0);
    chk({tag, " B out_valid"}, ov_b, 0);
    chk({tag, " C out_q"}, oq_c, 0);
    chk({tag, " C out_valid"}, ov_c, 0);
    chk({tag, " D out_q"}, oq_d, 0);
    chk({tag, " D out_valid"}, ov_d, 0);
  endtask

  initial begin
    rst = 1'b1; ins8 = '0; ins1 = '0; ins13 = '0; iv8 = 1'b0; iv13 = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk_reset("reset");
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Exhaustive combinational sweep, 10 time units per value.
    for (int x = 0; x < 256; x++) begin
      ins8 = x[7:0];
      ins1 = x[0];
      #5;
      chk("A out comb", out_a, (x == 255) ? 1 : 0);
      chk("B out comb", out_b, (x == 255) ? 1 : 0);
      chk("C out comb", out_c, x[0]);
      #5;
    end

    // Latency: FF then EF back to back, then hold with in_valid low.
    issue(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 13'h1FFF, 1'b1);
    issue(1'b1, 8'hEF, 1'b0, 1'b1, 1'b1, 13'h1FFE, 1'b0);
    idle();
    repeat (6) begin
      idle();
      chk("A out_q hold", oq_a, 0);
      chk("B out_q hold", oq_b, 0);
      chk("D out_q hold", oq_d, 0);
    end

    // Back-to-back directed vectors, one bubble.
    for (int i = 0; i < 8; i++) begin
      issue(tv8[i], t8[i], te8[i], te1[i], 1'b1, t13[i], te13[i]);
      #1;
      chk("D out comb", out_d, te13[i]);
    end
    repeat (3) idle();

    // Reset with results in flight and one result currently presented.
    issue(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 13'h1FFF, 1'b1);
    issue(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 13'h1FFF, 1'b1);
    @(posedge clk);
    #1;
    iv8 = 1'b0;
    iv13 = 1'b0;
    #2;
    rst = 1'b1;
    for (int id = 0; id < 4; id++) sbq[id].delete();
    #1;
    chk_reset("async rst");
    ins8 = 8'hFF; #1; chk("A out during rst", out_a, 1);
    ins8 = 8'h7F; #1; chk("A out during rst", out_a, 0);
    ins13 = 13'h1FFF; #1; chk("D out during rst", out_d, 1);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (5) idle();
    chk_reset("post rst idle");

    // Recovery after reset.
    issue(1'b1, 8'hFE, 1'b0, 1'b0, 1'b1, 13'h1FFF, 1'b1);
    issue(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 13'h0FFF, 1'b0);
    repeat (4) idle();

`ifdef AND_NWAY_ZERO_IDX_EN
    ins8 = 8'b1111_0111; #1;
    chk("zero_found F7", zf_a, 1);
    chk("zero_idx F7", zi_a, 3);
    ins8 = 8'b0111_1111; #1;
    chk("zero_idx 7F", zi_a, 7);
    ins8 = 8'hFF; #1;
    chk("zero_found FF", zf_a, 0);
    chk("zero_idx FF", zi_a, 0);
`endif

    repeat (3) idle();
    for (int id = 0; id < 4; id++) chk("scoreboard drained", sbq[id].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/and_nway_pipe.md
Name: and_nway_pipe

Overview:
- Parameterised N-input AND reduction for boolean/logic blocks.
- Provides an immediate combinational result and a registered, optionally pipelined result with a valid flag.
- Used wherever a wide all-ones detect is needed, either in a single cycle or as a timing-friendly pipelined tree.

Parameters:
- NB_IN, 8, number of input bits (>=1).
- PIPELINE, 1, 1 = register after every tree level; 0 = single output register.
- FANIN, 4, leaf/group width of the reduction tree (>=2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- out  output  1  combinational AND of all ins bits.
- ins  input  NB_IN  operand bits.
- in_valid  input  1  qualifies ins for the registered path.
- out_q  output  1  registered/pipelined AND result.
- out_valid  output  1  out_q carries a new result this cycle.

Behaviour:
- Declaration order starts with out, then ins, so positional instantiation (out, ins) works. Clock, reset and the remaining ports follow.
- Reset is asynchronous and active-high. While rst=1: all pipeline data registers=0, valid shift bits=0, out_q=0, out_valid=0.
- out = &ins at all times. It is purely combinational and independent of clk, rst and in_valid.
- Tree structure:
  - Inputs are grouped into FANIN-wide ANDs, level by level, until one bit remains.
  - Levels L = max(1, ceil(log_FANIN(NB_IN))).
  - Missing leaves in a partial group are tied to 1, so padding never forces 0.
- PIPELINE=1:
  - Each level is registered; latency = L cycles.
  - in_valid sampled at edge k produces out_valid=1 and out_q = &ins(sampled) after edge k+L-1, visible for one cycle.
- PIPELINE=0:
  - Full combinational tree, one register; latency = 1 cycle.
- Valid tracking:
  - A valid bit travels alongside each stage.
  - Stage data registers advance every cycle regardless of valid.
  - out_q updates only when the final-stage valid bit is 1; otherwise it holds its last value.
  - out_valid is a 1-cycle pulse per accepted input.
- Throughput: one input per cycle, with no back-pressure. Back-to-back valid inputs emerge back-to-back in order.
- Edge sizes:
  - NB_IN=1: out = ins[0]; L=1.
  - NB_IN <= FANIN: L=1.
- Reset mid-operation: all in-flight results are discarded, with no out_valid after deassert until new in_valid inputs propagate.
- X-free: no output depends on uninitialised state after reset.

Optional Feature:
- Macro AND_NWAY_ZERO_IDX_EN.
- When defined, adds two outputs:
  - zero_found (1 bit): = ~out, combinational.
  - zero_idx (ceil(log2 NB_IN) bits, minimum 1): index of the lowest-numbered 0 bit in ins, combinational; 0 when ins is all ones.
- When not defined, these ports and their logic do not exist. All other behaviour is identical in both cases.

Test Plan:
- Exhaustive, NB_IN=8: sweep ins 0..255, holding each for 10 time units. out=1 only for 8'hFF; 0 for all 255 other values, including 8'h7F and 8'hFE.
- Pipeline latency, NB_IN=8, FANIN=4, PIPELINE=1 (L=2): in_valid=1 with ins=8'hFF at edge 0. Response: out_valid=1 and out_q=1 after edge 1 only. Next cycle ins=8'hEF gives out_q=0 with out_valid=1 one cycle later.
- Hold and idle: after the results above, hold in_valid=0 for 5 cycles. out_valid stays 0 and out_q holds 0. PIPELINE=0 variant: latency is exactly 1 cycle.
- Reset: assert rst asynchronously (between edges) with 2 valid inputs in flight. out_q=0 and out_valid=0 immediately, and no stray out_valid after release. out still tracks ins during reset.
- Sizes: NB_IN=1 gives out=ins[0], with out_q following 1 cycle after in_valid. NB_IN=13, FANIN=4 (L=2, padded group): only 13'h1FFF yields 1.
- With AND_NWAY_ZERO_IDX_EN, NB_IN=8:
  - ins=8'b1111_0111: zero_found=1, zero_idx=3.
  - ins=8'b0111_1111: zero_idx=7.
  - ins=8'hFF: zero_found=0, zero_idx=0.
